pipeline_ctrl_chain: RTL and testbench
======================================

Name: pipeline_ctrl_chain

Overview:
- Parametrised multi-stage valid/ready pipeline controller with an optional payload path.
- Generalises the single-stage decoupled register controller to DEPTH stages, with an optional input skid buffer (registered in_ready), synchronous flush, occupancy count, and per-stage load enables.
- Sits between arithmetic stages of the floating-point units and drives external datapath registers through stage_en.

Parameters:
- DEPTH, 3, number of pipeline stages (>=1).
- DATA_W, 32, payload width carried alongside valid (0 not allowed; tie in_data off if unused).
- SKID, 0, 1 = insert a 1-entry skid buffer before stage 0 so in_ready is a register output.
- CNT_W, $clog2(DEPTH+2), occupancy counter width (derived; not to be overridden).

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all stage and skid contents
- in_valid  in  1  upstream valid
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  upstream ready
- out_valid  out  1  downstream valid (stage DEPTH-1)
- out_data  out  DATA_W  downstream payload
- out_ready  in  1  downstream ready
- stage_valid  out  DEPTH  valid bit of each stage register
- stage_en  out  DEPTH  load enable for external stage-i datapath register
- count  out  CNT_W  number of valid entries held (stages plus skid)

Behaviour:
- Reset (async): all stage valids, skid valid and count go to 0; data registers go to 0. At the first cycle after reset: out_valid=0, stage_valid=0, count=0, in_ready=1.
- Stage ready chain:
  - r[DEPTH]=out_ready.
  - r[i] = !v[i] || r[i+1] (combinational, bubble-collapsing).
- Stage source:
  - src_v[0]/src_d[0] = skid entry if SKID=1 and skid valid, otherwise in_valid/in_data.
  - src_v[i] = v[i-1] for i>0.
- Update: when r[i]=1, v[i] <= src_v[i]. When r[i] && src_v[i], d[i] <= src_d[i]. Otherwise the stage holds.
- stage_en[i] = r[i] && src_v[i] && !flush.
- SKID=0:
  - in_ready = r[0] && !flush (combinational from out_ready).
  - Latency with no backpressure is DEPTH cycles, throughput 1/cycle.
- SKID=1:
  - in_ready = !skid_v && !flush (registered term only).
  - If in_valid && in_ready && !r[0], the beat is written to the skid: skid_v<=1.
  - If skid_v && r[0], the skid drains into stage 0: skid_v<=0.
  - A skid write and drain never occur in the same cycle, because a write requires skid_v=0.
  - Latency is DEPTH cycles when the skid is empty. No beat is ever dropped or duplicated.
- Flush:
  - Takes priority over every transfer.
  - While flush=1: in_ready=0, out_valid=0, stage_en=0.
  - Next cycle: all v[i], skid_v and count are 0. Data registers are not cleared.
- count:
  - Tracks the popcount of v[] plus skid_v, updated registered.
  - Increments on an accepted input (in_valid && in_ready), decrements on out_valid && out_ready; both in the same cycle means no change.
  - Range is 0..DEPTH+SKID. It can never overflow or underflow.
- Full pipeline with out_ready=0: every r[i]=0, SKID=0 gives in_ready=0, and all data holds stable.
- out_valid must not drop without a handshake or flush. out_data must stay stable while out_valid && !out_ready.

Decomposition:
- Shared package: pipeline_ctrl_pkg holding a clog2 helper function and the SKID mode constants (SKID_NONE=0, SKID_ONE=1).
- One natural sub-module, pipe_skid_buf: a 1-entry skid buffer with valid, data, in_ready and drain, instantiated under generate when SKID=1.
- Stages are a generate loop; no per-stage sub-module.

Test Plan:
- DEPTH=3, SKID=0, out_ready=1, inject 0x11,0x22,0x33 back-to-back from cycle 1 -> out_data 0x11/0x22/0x33 on cycles 4/5/6, count peaks at 3, in_ready stays 1.
- DEPTH=3, SKID=0, out_ready=0, stream 5 beats -> accepts exactly 3, in_ready=0 with count=3. Release out_ready -> beats drain in order with no loss.
- DEPTH=3, SKID=1, out_ready=0, stream beats -> 4 accepted, count=4, in_ready=0 the cycle after the 4th acceptance. Release -> 4 beats out in order and in_ready returns to 1.
- Bubble collapse: DEPTH=4, only stage 3 valid and stalled, inject 1 beat -> beat advances to stage 2 over 3 cycles while out_ready=0, count=2.
- Flush with count=3 and out_valid=1 -> during the flush cycle out_valid=0 and in_ready=0; next cycle count=0 and stage_valid=0. A beat offered during flush is not accepted.
- Assert reset mid-stream with count=2 -> outputs clear immediately (async), out_valid=0. After release, a new beat appears DEPTH cycles after acceptance.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and helpers for the multi-stage valid/ready pipeline controller.
package pipeline_ctrl_pkg;

  // Skid-buffer modes for the SKID parameter
  localparam int SKID_NONE = 0;
  localparam int SKID_ONE  = 1;

  // Ceiling log2, used to size the occupancy counter at elaboration time
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_chain_skid.sv
// One-entry skid buffer in front of stage 0. in_ready depends only on the
// stored valid bit and flush, which breaks the combinational ready path.
module pipe_skid_buf
  import pipeline_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_down_ready,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_write;
  logic              w_drain;

  // A write needs an empty entry, so write and drain are mutually exclusive
  assign o_ready = !r_valid && !i_flush;
  assign w_write = i_valid && o_ready && !i_down_ready;
  assign w_drain = r_valid && i_down_ready;

  // Park a beat stage 0 cannot take; release it as soon as stage 0 frees up
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_W{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_write) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipeline_ctrl_chain.sv
// DEPTH-stage valid/ready pipeline controller with bubble collapsing, an
// optional input skid buffer, synchronous flush and an occupancy counter.
// stage_en drives the load enables of external per-stage datapath registers.
module pipeline_ctrl_chain
  import pipeline_ctrl_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32,
  parameter int SKID   = SKID_NONE,
  parameter int CNT_W  = clog2(DEPTH + 2)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [DEPTH-1:0]  stage_en,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH:0]    w_ready;
  logic [DEPTH-1:0]  w_v;
  logic [DEPTH-1:0]  w_src_v;
  logic [DATA_W-1:0] w_d     [DEPTH];
  logic [DATA_W-1:0] w_src_d [DEPTH];
  logic              w_skid_v;
  logic [DATA_W-1:0] w_skid_d;
  logic              w_accept;
  logic              w_retire;
  logic [CNT_W-1:0]  r_count;

  // Ready chain: a stage can load when it is empty or its content moves on
  always_comb begin
    w_ready        = {(DEPTH+1){1'b0}};
    w_ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_ready[i] = !w_v[i] || w_ready[i+1];
    end
  end

  // Optional skid buffer; without it in_ready follows the ready chain directly
  if (SKID == SKID_ONE) begin : g_skid
    pipe_skid_buf #(
      .DATA_W(DATA_W)
    ) u_skid (
      .clock       (clock),
      .reset       (reset),
      .i_flush     (flush),
      .i_valid     (in_valid),
      .i_data      (in_data),
      .i_down_ready(w_ready[0]),
      .o_ready     (in_ready),
      .o_valid     (w_skid_v),
      .o_data      (w_skid_d)
    );
  end else begin : g_no_skid
    assign w_skid_v = 1'b0;
    assign w_skid_d = {DATA_W{1'b0}};
    assign in_ready = w_ready[0] && !flush;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic              r_v;
    logic [DATA_W-1:0] r_d;

    if (g == 0) begin : g_src_head
      // A parked skid beat always goes before new upstream data
      assign w_src_v[g] = w_skid_v || in_valid;
      assign w_src_d[g] = w_skid_v ? w_skid_d : in_data;
    end else begin : g_src_prev
      assign w_src_v[g] = w_v[g-1];
      assign w_src_d[g] = w_d[g-1];
    end

    // Load from the upstream source whenever this stage is ready; flush empties it
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_v <= 1'b0;
        r_d <= {DATA_W{1'b0}};
      end else if (flush) begin
        r_v <= 1'b0;
      end else if (w_ready[g]) begin
        r_v <= w_src_v[g];
        if (w_src_v[g]) begin
          r_d <= w_src_d[g];
        end else begin
          r_d <= r_d;
        end
      end else begin
        r_v <= r_v;
      end
    end

    assign w_v[g]      = r_v;
    assign w_d[g]      = r_d;
    assign stage_en[g] = w_ready[g] && w_src_v[g] && !flush;
  end

  assign out_valid   = w_v[DEPTH-1] && !flush;
  assign out_data    = w_d[DEPTH-1];
  assign stage_valid = w_v;

  assign w_accept = in_valid && in_ready;
  assign w_retire = out_valid && out_ready;

  // Occupancy: +1 per accepted beat, -1 per delivered beat, cleared by flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (flush) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_pipeline_ctrl_chain.sv
// Bench for pipeline_ctrl_chain: three instances (DEPTH3/no skid, DEPTH3/skid,
// DEPTH4/no skid) checked every cycle against a slot-shifting reference model
// and an in-order scoreboard, plus directed scenario checks.
module tb_pipeline_ctrl_chain;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] flush;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [7:0] in_data  [3];
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [7:0] out_data [3];
  logic [2:0] sv0, sv1, en0, en1, cnt0, cnt1, cnt2;
  logic [3:0] sv2, en2;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // reference model state: slots per instance, skid entry, scoreboard queue
  bit         mv   [3][4];
  logic [7:0] md   [3][4];
  bit         ms   [3];
  logic [7:0] msd  [3];
  bit         nmv  [3][4];
  logic [7:0] nmd  [3][4];
  bit         nms  [3];
  logic [7:0] nmsd [3];
  bit         e_ir [3];
  bit         e_ov [3];
  bit         e_acc[3];
  bit         e_pop[3];
  logic [3:0] e_en [3];
  logic [7:0] sbq  [3][$];

  always #5 clock = ~clock;

  pipeline_ctrl_chain #(.DEPTH(3), .DATA_W(8), .SKID(0)) u_d3s0 (
    .clock(clock), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready[0]), .stage_valid(sv0),
    .stage_en(en0), .count(cnt0));

  pipeline_ctrl_chain #(.DEPTH(3), .DATA_W(8), .SKID(1)) u_d3s1 (
    .clock(clock), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready[1]), .stage_valid(sv1),
    .stage_en(en1), .count(cnt1));

  pipeline_ctrl_chain #(.DEPTH(4), .DATA_W(8), .SKID(0)) u_d4s0 (
    .clock(clock), .reset(reset), .flush(flush[2]), .in_valid(in_valid[2]),
    .in_data(in_data[2]), .in_ready(in_ready[2]), .out_valid(out_valid[2]),
    .out_data(out_data[2]), .out_ready(out_ready[2]), .stage_valid(sv2),
    .stage_en(en2), .count(cnt2));

  function automatic int dep(input int k);
    return (k == 2) ? 4 : 3;
  endfunction

  function automatic bit sk(input int k);
    return (k == 1);
  endfunction

  function automatic logic [3:0] get_sv(input int k);
    case (k)
      0:       return {1'b0, sv0};
      1:       return {1'b0, sv1};
      default: return sv2;
    endcase
  endfunction

  function automatic logic [3:0] get_en(input int k);
    case (k)
      0:       return {1'b0, en0};
      1:       return {1'b0, en1};
      default: return en2;
    endcase
  endfunction

  function automatic logic [2:0] get_cnt(input int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
      ms[k] = 1'b0;
      sbq[k].delete();
    end
  endtask

  // Predict this cycle's outputs and the next slot contents from current inputs
  task automatic model_eval(input int k);
    int d;
    bit room;
    d = dep(k);
    e_ov[k] = mv[k][d-1] && !flush[k];
    room = out_ready[k];
    for (int i = 0; i < d; i++) if (!mv[k][i]) room = 1'b1;
    if (flush[k]) e_ir[k] = 1'b0;
    else if (sk(k)) e_ir[k] = !ms[k];
    else e_ir[k] = room;
    e_acc[k] = in_valid[k] && e_ir[k];
    e_pop[k] = e_ov[k] && out_ready[k];
    e_en[k] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      nmv[k][i] = mv[k][i];
      nmd[k][i] = md[k][i];
    end
    nms[k] = ms[k];
    nmsd[k] = msd[k];
    if (flush[k]) begin
      for (int i = 0; i < 4; i++) nmv[k][i] = 1'b0;
      nms[k] = 1'b0;
    end else begin
      if (e_pop[k]) nmv[k][d-1] = 1'b0;
      for (int i = d - 2; i >= 0; i--) begin
        if (nmv[k][i] && !nmv[k][i+1]) begin
          nmv[k][i+1] = 1'b1;
          nmd[k][i+1] = nmd[k][i];
          nmv[k][i] = 1'b0;
          e_en[k][i+1] = 1'b1;
        end
      end
      if (!nmv[k][0]) begin
        if (ms[k]) begin
          nmv[k][0] = 1'b1; nmd[k][0] = msd[k]; nms[k] = 1'b0; e_en[k][0] = 1'b1;
        end else if (e_acc[k]) begin
          nmv[k][0] = 1'b1; nmd[k][0] = in_data[k]; e_en[k][0] = 1'b1;
        end
      end else if (e_acc[k]) begin
        nms[k] = 1'b1; nmsd[k] = in_data[k];
      end
    end
  endtask

  task automatic compare(input int k);
    int pc;
    logic [3:0] esv;
    pc = ms[k];
    esv = 4'b0000;
    for (int i = 0; i < dep(k); i++) begin
      pc += mv[k][i];
      esv[i] = mv[k][i];
    end
    chk($sformatf("u%0d_in_ready", k), 32'(in_ready[k]), 32'(e_ir[k]));
    chk($sformatf("u%0d_out_valid", k), 32'(out_valid[k]), 32'(e_ov[k]));
    if (e_ov[k])
      chk($sformatf("u%0d_out_data", k), 32'(out_data[k]),
          32'((sbq[k].size() > 0) ? sbq[k][0] : 8'hxx));
    chk($sformatf("u%0d_stage_valid", k), 32'(get_sv(k)), 32'(esv));
    chk($sformatf("u%0d_stage_en", k), 32'(get_en(k)), 32'(e_en[k]));
    chk($sformatf("u%0d_count", k), 32'(get_cnt(k)), 32'(pc));
  endtask

  task automatic commit(input int k);
    if (flush[k]) begin
      sbq[k].delete();
    end else begin
      if (e_pop[k]) void'(sbq[k].pop_front());
      if (e_acc[k]) sbq[k].push_back(in_data[k]);
    end
    for (int i = 0; i < 4; i++) begin
      mv[k][i] = nmv[k][i];
      md[k][i] = nmd[k][i];
    end
    ms[k] = nms[k];
    msd[k] = nmsd[k];
  endtask

  task automatic pre_check();
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      model_eval(k);
      compare(k);
    end
  endtask

  task automatic post_commit();
    @(posedge clock);
    if (reset) model_reset();
    else for (int k = 0; k < 3; k++) commit(k);
    #1;
  endtask

  task automatic cyc();
    pre_check();
    post_commit();
  endtask

  initial begin
    int n;
    int got;
    reset = 1'b1;
    flush = 3'b000;
    in_valid = 3'b000;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) in_data[k] = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd7);
    chk("rst_count0", 32'(cnt0), 32'd0);
    chk("rst_stage_valid2", 32'(sv2), 32'd0);
    reset = 1'b0;

    // back-to-back stream, no backpressure
    for (int c = 1; c <= 7; c++) begin
      in_valid[0] = (c <= 3);
      in_data[0] = 8'(17 * c);
      pre_check();
      if (c <= 3) chk("t1_in_ready", 32'(in_ready[0]), 32'd1);
      if (c >= 4 && c <= 6) begin
        chk("t1_out_valid", 32'(out_valid[0]), 32'd1);
        chk("t1_out_data", 32'(out_data[0]), 32'(17 * (c - 3)));
      end
      if (c == 4) chk("t1_count_peak", 32'(cnt0), 32'd3);
      post_commit();
    end

    // stalled output: only DEPTH beats fit
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      in_data[0] = 8'(8'hA0 + n);
      pre_check();
      if (in_ready[0]) n++;
      post_commit();
    end
    in_valid[0] = 1'b0;
    pre_check();
    chk("t2_accepted", 32'(n), 32'd3);
    chk("t2_count", 32'(cnt0), 32'd3);
    chk("t2_in_ready", 32'(in_ready[0]), 32'd0);
    post_commit();
    out_ready[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      pre_check();
      if (out_valid[0]) begin
        chk("t2_drain_data", 32'(out_data[0]), 32'(8'hA0 + got));
        got++;
      end
      post_commit();
    end
    chk("t2_drained", 32'(got), 32'd3);

    // skid instance holds DEPTH+1 beats
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      in_data[1] = 8'(8'hB0 + n);
      pre_check();
      if (in_ready[1]) n++;
      post_commit();
    end
    in_valid[1] = 1'b0;
    pre_check();
    chk("t3_accepted", 32'(n), 32'd4);
    chk("t3_count", 32'(cnt1), 32'd4);
    chk("t3_in_ready", 32'(in_ready[1]), 32'd0);
    post_commit();
    out_ready[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      pre_check();
      if (out_valid[1]) begin
        chk("t3_drain_data", 32'(out_data[1]), 32'(8'hB0 + got));
        got++;
      end
      post_commit();
    end
    chk("t3_drained", 32'(got), 32'd4);
    pre_check();
    chk("t3_in_ready_back", 32'(in_ready[1]), 32'd1);
    post_commit();

    // bubble collapse behind a stalled last stage
    out_ready[2] = 1'b0;
    in_valid[2] = 1'b1;
    in_data[2] = 8'hC1;
    cyc();
    in_valid[2] = 1'b0;
    repeat (3) cyc();
    pre_check();
    chk("t4_only_last", 32'(sv2), 32'h8);
    post_commit();
    in_valid[2] = 1'b1;
    in_data[2] = 8'hC2;
    cyc();
    in_valid[2] = 1'b0;
    repeat (2) cyc();
    pre_check();
    chk("t4_stage_valid", 32'(sv2), 32'hC);
    chk("t4_count", 32'(cnt2), 32'd2);
    chk("t4_out_valid", 32'(out_valid[2]), 32'd1);
    post_commit();

    // flush of a full, stalled pipeline
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data[0] = 8'(8'hD0 + c);
      cyc();
    end
    in_valid[0] = 1'b0;
    pre_check();
    chk("t5_pre_count", 32'(cnt0), 32'd3);
    chk("t5_pre_out_valid", 32'(out_valid[0]), 32'd1);
    post_commit();
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = 8'hEE;
    pre_check();
    chk("t5_flush_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t5_flush_in_ready", 32'(in_ready[0]), 32'd0);
    chk("t5_flush_stage_en", 32'(en0), 32'd0);
    post_commit();
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    pre_check();
    chk("t5_post_count", 32'(cnt0), 32'd0);
    chk("t5_post_stage_valid", 32'(sv0), 32'd0);
    post_commit();

    // asynchronous reset in the middle of traffic
    in_valid[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_data[0] = 8'(8'h70 + c);
      cyc();
    end
    in_valid[0] = 1'b0;
    pre_check();
    chk("t6_pre_count", 32'(cnt0), 32'd2);
    post_commit();
    reset = 1'b1;
    #1;
    chk("t6_rst_count", 32'(cnt0), 32'd0);
    chk("t6_rst_stage_valid", 32'(sv0), 32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    model_reset();
    cyc();
    reset = 1'b0;
    out_ready = 3'b111;
    in_valid[0] = 1'b1;
    in_data[0] = 8'h5A;
    pre_check();
    chk("t6_accept", 32'(in_ready[0]), 32'd1);
    post_commit();
    in_valid[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      pre_check();
      if (c < 3) begin
        chk("t6_not_yet", 32'(out_valid[0]), 32'd0);
      end else begin
        chk("t6_out_valid", 32'(out_valid[0]), 32'd1);
        chk("t6_out_data", 32'(out_data[0]), 32'h5A);
      end
      post_commit();
    end

    // randomized traffic on all three instances
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        in_valid[k] = ($urandom_range(0, 3) != 0);
        in_data[k] = 8'($urandom);
        out_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k] = ($urandom_range(0, 24) == 0);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
